// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: reader FSM states, hex glyph table
// and a glyph decoder returning {legal, value}.
package seg_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1
    } state_e;

    // Bit order {A,B,C,D,E,F,G}, lit segment = 1
    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
        GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
        GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (s == GLYPHS[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_stab_filter.sv
// Captures the segment bus and raises a one-shot accept once a new
// pattern has held for STABLE enabled edges.
module seg_stab_filter
    import seg_pkg::*;
#(
    parameter int STABLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] seg_in,
    output logic       acc_valid,
    output logic [6:0] acc_pat
);

    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE - 1);

    logic [6:0]    seg_q, seg_d;
    logic [CW-1:0] stab_cnt_q, stab_cnt_d;
    logic          acc_valid_q, acc_valid_d;
    logic [6:0]    acc_pat_q, acc_pat_d;

    // acc_pat_q doubles as the last accepted pattern, so a glitch that
    // returns to it does not produce a second acceptance.
    always_comb begin
        seg_d       = seg_q;
        stab_cnt_d  = stab_cnt_q;
        acc_valid_d = acc_valid_q;
        acc_pat_d   = acc_pat_q;
        if (en) begin
            seg_d       = seg_in;
            acc_valid_d = 1'b0;
            if (seg_in != seg_q) begin
                stab_cnt_d = '0;
            end else if (stab_cnt_q != CNT_MAX) begin
                stab_cnt_d = stab_cnt_q + 1'b1;
            end
            if (stab_cnt_d == CNT_ACC && seg_in != acc_pat_q) begin
                acc_valid_d = 1'b1;
                acc_pat_d   = seg_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '0;
            stab_cnt_q  <= '0;
            acc_valid_q <= 1'b0;
            acc_pat_q   <= '0;
        end else begin
            seg_q       <= seg_d;
            stab_cnt_q  <= stab_cnt_d;
            acc_valid_q <= acc_valid_d;
            acc_pat_q   <= acc_pat_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_pat   = acc_pat_q;

endmodule

// File: rtl/seg_reader.sv
// Seven-segment readback monitor: decodes accepted glyphs and checks
// step direction, cadence and glyph legality.
module seg_reader
    import seg_pkg::*;
#(
    parameter int PERIOD          = 3,
    parameter int MOD             = 8,
    parameter int STABLE          = 2,
    parameter int SEG_ACTIVE_HIGH = 1
) (
    input  logic       eck,
    input  logic       er,
    input  logic       eena,
    input  logic [6:0] seg,
    input  logic       down,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err_code,
    output logic       err_step,
    output logic       err_time,
    output logic [7:0] err_count,
    output logic [1:0] state
);

    localparam int IW = $clog2(2 * PERIOD + 1);
    localparam logic [IW-1:0] IVL_MAX = IW'(2 * PERIOD);
    localparam logic [IW-1:0] IVL_HIT = IW'(PERIOD - 1);
    localparam logic [3:0]    DIG_TOP = 4'(MOD - 1);

    logic [6:0] seg_pol;
    logic       acc_valid;
    logic [6:0] acc_pat;

    assign seg_pol = (SEG_ACTIVE_HIGH != 0) ? seg : ~seg;

    seg_stab_filter #(
        .STABLE(STABLE)
    ) u_filt (
        .clk      (eck),
        .rst_n    (er),
        .en       (eena),
        .seg_in   (seg_pol),
        .acc_valid(acc_valid),
        .acc_pat  (acc_pat)
    );

    state_e     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic [IW-1:0] ivl_q, ivl_d;
    logic       err_code_q, err_code_d;
    logic       err_step_q, err_step_d;
    logic       err_time_q, err_time_d;
    logic [7:0] err_count_q, err_count_d;
    logic [4:0] dec;
    logic [3:0] nxt;

    assign dec = seg_decode(acc_pat);

    // Successor of the held digit; out-of-range digits map into range
    always_comb begin
        if (down) begin
            nxt = (digit_q == 4'd0 || digit_q > DIG_TOP) ? DIG_TOP
                                                         : digit_q - 4'd1;
        end else begin
            nxt = (digit_q >= DIG_TOP) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        ivl_d       = ivl_q;
        err_code_d  = 1'b0;
        err_step_d  = 1'b0;
        err_time_d  = 1'b0;
        err_count_d = err_count_q;
        if (eena) begin
            if (state_q == TRACK && ivl_q != IVL_MAX) ivl_d = ivl_q + 1'b1;
            if (acc_valid) begin
                ivl_d = '0;
                if (!dec[4]) begin
                    err_code_d = 1'b1;
                    state_d    = SYNC;
                end else begin
                    digit_d = dec[3:0];
                    state_d = TRACK;
                    if (state_q == TRACK) begin
                        err_step_d = (dec[3:0] != nxt);
                        err_time_d = (ivl_q != IVL_HIT);
                    end
                end
            end
            if ((err_code_d || err_step_d || err_time_d) &&
                err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge eck or negedge er) begin
        if (!er) begin
            state_q     <= SYNC;
            digit_q     <= '0;
            ivl_q       <= '0;
            err_code_q  <= 1'b0;
            err_step_q  <= 1'b0;
            err_time_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            ivl_q       <= ivl_d;
            err_code_q  <= err_code_d;
            err_step_q  <= err_step_d;
            err_time_q  <= err_time_d;
            err_count_q <= err_count_d;
        end
    end

    assign digit     = digit_q;
    assign valid     = (state_q == TRACK);
    assign err_code  = err_code_q;
    assign err_step  = err_step_q;
    assign err_time  = err_time_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader with a run-length reference model
// compared every cycle plus hand-computed spot checks.
module tb_seg_reader;

    localparam int PERIOD = 3;
    localparam int MOD    = 8;
    localparam int STABLE = 2;
    localparam int SAH    = 1;

    localparam logic [6:0] GL [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    localparam logic [6:0] ILL1  = 7'h01;
    localparam logic [6:0] ILL2  = 7'h02;
    localparam logic [6:0] BLANK = 7'h00;

    logic       eck = 1'b0;
    logic       er;
    logic       eena;
    logic [6:0] seg;
    logic       down;
    logic [3:0] digit;
    logic       valid;
    logic       err_code;
    logic       err_step;
    logic       err_time;
    logic [7:0] err_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    seg_reader #(
        .PERIOD(PERIOD), .MOD(MOD), .STABLE(STABLE), .SEG_ACTIVE_HIGH(SAH)
    ) dut (
        .eck(eck), .er(er), .eena(eena), .seg(seg), .down(down),
        .digit(digit), .valid(valid), .err_code(err_code),
        .err_step(err_step), .err_time(err_time),
        .err_count(err_count), .state(state)
    );

    always #5 eck = ~eck;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: acceptance after STABLE equal enabled samples,
    // applied on the following enabled edge; interval in enabled edges.
    typedef struct packed {
        int         n;
        int         last_acc;
        int         run;
        logic [6:0] last_p;
        logic [6:0] lap;
        logic       pend;
        logic [6:0] pend_pat;
        logic       trk;
        logic [3:0] dig;
        logic       ec;
        logic       es;
        logic       et;
        int         errs;
    } mst_t;

    function automatic int mdec(input logic [6:0] p);
        int v;
        v = -1;
        for (int i = 0; i < 16; i++) if (GL[i] == p) v = i;
        return v;
    endfunction

    function automatic mst_t mstep(input mst_t m, input logic en,
                                   input logic [6:0] s_raw, input logic dn);
        mst_t r;
        logic [6:0] s;
        int v;
        int ex;
        r = m;
        r.ec = 1'b0;
        r.es = 1'b0;
        r.et = 1'b0;
        if (!en) return r;
        s = (SAH != 0) ? s_raw : ~s_raw;
        r.n = m.n + 1;
        if (m.pend) begin
            v = mdec(m.pend_pat);
            if (v < 0) begin
                r.ec  = 1'b1;
                r.trk = 1'b0;
            end else begin
                if (m.trk) begin
                    ex = dn ? (int'(m.dig) + MOD - 1) % MOD
                            : (int'(m.dig) + 1) % MOD;
                    r.es = (v != ex);
                    r.et = ((r.n - m.last_acc) != PERIOD);
                end
                r.dig      = 4'(v);
                r.trk      = 1'b1;
                r.last_acc = r.n;
            end
        end
        r.pend = 1'b0;
        if (s != m.last_p) r.run = 1;
        else if (m.run < STABLE) r.run = m.run + 1;
        r.last_p = s;
        if (r.run == STABLE && (s != m.last_p || m.run != STABLE)
            && s != m.lap) begin
            r.pend     = 1'b1;
            r.pend_pat = s;
            r.lap      = s;
        end
        if (r.ec || r.es || r.et) r.errs = (m.errs < 255) ? m.errs + 1 : 255;
        return r;
    endfunction

    mst_t m;

    always @(posedge eck or negedge er) begin
        if (!er) m <= '0;
        else m <= mstep(m, eena, seg, down);
    end

    always @(negedge eck) begin
        chk("digit", int'(digit), int'(m.dig));
        chk("valid", int'(valid), int'(m.trk));
        chk("state", int'(state), int'(m.trk));
        chk("err_code", int'(err_code), int'(m.ec));
        chk("err_step", int'(err_step), int'(m.es));
        chk("err_time", int'(err_time), int'(m.et));
        chk("err_count", int'(err_count), m.errs);
    end

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge eck);
    endtask

    initial begin
        er   = 1'b0;
        eena = 1'b1;
        seg  = GL[0];
        down = 1'b0;
        repeat (2) @(negedge eck);
        chk("rst_digit", int'(digit), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(err_count), 0);
        er = 1'b1;

        // Clean up-count with wrap 7 -> 0
        for (int i = 0; i < 8; i++) hold(GL[i], 3);
        hold(GL[0], 3);
        chk("up_digit", int'(digit), 0);
        chk("up_valid", int'(valid), 1);
        chk("up_count", int'(err_count), 0);

        // Down-count through the 0 -> 7 wrap
        hold(GL[1], 3);
        hold(GL[2], 3);
        down = 1'b1;
        hold(GL[1], 3);
        hold(GL[0], 3);
        hold(GL[7], 3);
        chk("dn_digit", int'(digit), 7);
        chk("dn_count", int'(err_count), 0);

        // Skip 2 -> 4 with a late change: step and time on one edge
        down = 1'b0;
        hold(GL[0], 3);
        hold(GL[1], 3);
        hold(GL[2], 4);
        hold(GL[4], 2);
        hold(GL[5], 1);
        chk("skip_step", int'(err_step), 1);
        chk("skip_time", int'(err_time), 1);
        chk("skip_count", int'(err_count), 1);
        hold(GL[5], 2);

        // Illegal glyph drops to SYNC; next legal glyph reacquires
        hold(ILL1, 2);
        hold(GL[5], 1);
        chk("ill_code", int'(err_code), 1);
        chk("ill_valid", int'(valid), 0);
        chk("ill_state", int'(state), 0);
        chk("ill_digit", int'(digit), 5);
        hold(GL[5], 2);
        chk("acq_digit", int'(digit), 5);
        chk("acq_state", int'(state), 1);
        chk("acq_count", int'(err_count), 3);

        // One-edge blank glitch inside a held digit
        hold(GL[6], 3);
        hold(GL[7], 2);
        hold(BLANK, 1);
        hold(GL[7], 2);
        chk("glitch_count", int'(err_count), 3);
        chk("glitch_digit", int'(digit), 7);

        // Enable dropped for 10 edges mid-hold: cadence unaffected
        hold(GL[0], 3);
        hold(GL[1], 3);
        hold(GL[2], 3);
        hold(GL[3], 1);
        eena = 1'b0;
        repeat (10) @(negedge eck);
        eena = 1'b1;
        hold(GL[3], 2);
        hold(GL[4], 3);
        chk("ena_count", int'(err_count), 4);
        chk("ena_digit", int'(digit), 4);

        // Asynchronous reset in the middle of a hold
        hold(GL[5], 3);
        hold(GL[6], 1);
        #2 er = 1'b0;
        #1;
        chk("arst_digit", int'(digit), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_count", int'(err_count), 0);
        chk("arst_pulse", int'({err_code, err_step, err_time}), 0);
        @(negedge eck);
        er = 1'b1;
        hold(GL[6], 3);
        chk("reacq_digit", int'(digit), 6);
        chk("reacq_state", int'(state), 1);
        chk("reacq_count", int'(err_count), 0);

        // 320 illegal acceptances saturate the counter
        for (int i = 0; i < 160; i++) begin
            hold(ILL1, 2);
            hold(ILL2, 2);
        end
        hold(ILL1, 3);
        chk("sat_count", int'(err_count), 255);
        chk("sat_state", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
